// File: rtl/led_sched_pkg.sv
// Shared definitions for the LED frame scheduler: FSM encoding and WS2811 frame constants.
package led_sched_pkg;

  typedef enum logic [1:0] {StIdle, StLatch, StSend, StGap} sched_state_e;

  localparam int unsigned LED_WORD_W         = 24;
  localparam int unsigned DEF_LED_COUNT      = 11;
  localparam int unsigned DEF_GAP_CYCLES     = 2500;  // 50 us latch gap at 50 MHz
  localparam int unsigned DEF_TIMEOUT        = 500000;
  localparam int unsigned SRC_W              = 2;     // source index width, N_SRC <= 4

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_frame_scheduler_if.sv
// Producer/driver-facing signal bundle of the LED frame scheduler.
interface led_frame_scheduler_if
  import led_sched_pkg::*;
#(
  parameter int unsigned N_SRC     = 3,
  parameter int unsigned LED_COUNT = DEF_LED_COUNT
);
  logic [N_SRC-1:0]                  req;
  logic [N_SRC*LED_COUNT*LED_WORD_W-1:0] frame_in;
  logic [N_SRC-1:0]                  grant;
  logic [SRC_W-1:0]                  active_src;
  logic                              busy;
  logic                              drv_enable;
  logic [LED_COUNT*LED_WORD_W-1:0]   drv_frame;
  logic                              drv_frame_done;
  logic                              frame_done;
  logic                              timeout_err;

  modport master (
    output req, frame_in, drv_frame_done,
    input  grant, active_src, busy, drv_enable, drv_frame, frame_done, timeout_err
  );

  modport slave (
    input  req, frame_in, drv_frame_done,
    output grant, active_src, busy, drv_enable, drv_frame, frame_done, timeout_err
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_i, wrapping modulo N_SRC.
module rr_arbiter
  import led_sched_pkg::*;
#(
  parameter int unsigned N_SRC = 3
) (
  input  logic [N_SRC-1:0] req_i,
  input  logic [SRC_W-1:0] last_i,
  output logic [N_SRC-1:0] grant_o,
  output logic [SRC_W-1:0] idx_o,
  output logic             valid_o
);

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    for (int off = 1; off <= int'(N_SRC); off++) begin
      int cand;
      cand = (int'(last_i) + off) % int'(N_SRC);
      if (!valid_o && req_i[cand]) begin
        valid_o       = 1'b1;
        idx_o         = SRC_W'(cand);
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_frame_scheduler.sv
// Grants one LED frame producer per frame, shadows its frame for the WS2811 driver,
// and enforces the post-frame latch gap and a SEND timeout.
module led_frame_scheduler
  import led_sched_pkg::*;
#(
  parameter int unsigned N_SRC      = 3,
  parameter int unsigned LED_COUNT  = DEF_LED_COUNT,
  parameter int unsigned GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT
) (
  input logic                  clock,
  input logic                  reset,
  led_frame_scheduler_if.slave bus
);

  localparam int unsigned FrameW = LED_COUNT * LED_WORD_W;
  localparam int unsigned CntMax = max_u(GAP_CYCLES, TIMEOUT);
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT - 1);
  localparam logic [CntW-1:0] GapLast     = CntW'(GAP_CYCLES - 1);

  sched_state_e      state_q, state_d;
  logic [N_SRC-1:0]  win_oh_q, win_oh_d;
  logic [SRC_W-1:0]  win_idx_q, win_idx_d;
  logic [SRC_W-1:0]  last_grant_q, last_grant_d;
  logic [SRC_W-1:0]  active_src_q, active_src_d;
  logic [FrameW-1:0] drv_frame_q, drv_frame_d;
  logic              frame_done_q, frame_done_d;
  logic              timeout_err_q, timeout_err_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [N_SRC-1:0]  arb_oh;
  logic [SRC_W-1:0]  arb_idx;
  logic              arb_valid;

  rr_arbiter #(
    .N_SRC (N_SRC)
  ) u_rr_arbiter (
    .req_i   (bus.req),
    .last_i  (last_grant_q),
    .grant_o (arb_oh),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    state_d       = state_q;
    win_oh_d      = win_oh_q;
    win_idx_d     = win_idx_q;
    last_grant_d  = last_grant_q;
    active_src_d  = active_src_q;
    drv_frame_d   = drv_frame_q;
    frame_done_d  = 1'b0;
    timeout_err_d = timeout_err_q;

    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          win_oh_d  = arb_oh;
          win_idx_d = arb_idx;
          state_d   = StLatch;
        end
      end
      StLatch: begin
        drv_frame_d  = bus.frame_in[win_idx_q * FrameW +: FrameW];
        active_src_d = win_idx_q;
        last_grant_d = win_idx_q;
        state_d      = StSend;
      end
      StSend: begin
        // A done pulse on the final allowed cycle still counts as a clean frame.
        if (bus.drv_frame_done) begin
          frame_done_d = 1'b1;
          state_d      = StGap;
        end else if (cnt_q == TimeoutLast) begin
          timeout_err_d = 1'b1;
          state_d       = StGap;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Shared counter restarts on every state change and saturates instead of wrapping.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q == '1) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= StIdle;
      win_oh_q      <= '0;
      win_idx_q     <= '0;
      last_grant_q  <= SRC_W'(N_SRC - 1);
      active_src_q  <= '0;
      drv_frame_q   <= '0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      win_oh_q      <= win_oh_d;
      win_idx_q     <= win_idx_d;
      last_grant_q  <= last_grant_d;
      active_src_q  <= active_src_d;
      drv_frame_q   <= drv_frame_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.grant       = (state_q == StLatch) ? win_oh_q : '0;
  assign bus.busy        = (state_q != StIdle);
  assign bus.drv_enable  = (state_q == StSend);
  assign bus.active_src  = active_src_q;
  assign bus.drv_frame   = drv_frame_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.timeout_err = timeout_err_q;

endmodule
